// File: rtl/req_capture_seq_pkg.sv
// Shared definitions for the request capture sequencer: FSM state encoding
// and the default request-line count / index width.
package req_capture_seq_pkg;

  localparam int DEF_N_REQ = 16;
  localparam int DEF_IDX_W = 4;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

endpackage

// File: rtl/pri_pick_16.sv
// Combinational priority picker: index of the highest set bit of a 16-bit
// vector (bit 15 wins), plus a flag telling whether any bit is set.
// When no bit is set the index reads 0 and any_set is low.
module pri_pick_16 (
  input  logic [15:0] vec,
  output logic [3:0]  idx,
  output logic        any_set
);

  // Scan upward so the highest set bit is the last one to write idx.
  always_comb begin
    idx = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (vec[i]) idx = 4'(i);
    end
  end

  assign any_set = |vec;

endmodule

// File: rtl/req_capture_seq.sv
// Request capture sequencer: detects rising edges on level request lines,
// holds them as pending, and offers them one at a time (highest index first)
// on a valid/ready output port. Lost re-requests are logged as sticky
// overflow flags.
//
// Output handshake: out_valid is high only in OFFER. While out_valid is high
// bin_out is held stable. A transfer happens on a rising clock edge where
// out_valid and out_ready are both high; that edge clears the serviced
// pending bit and returns the FSM to IDLE for at least one cycle.
module req_capture_seq
  import req_capture_seq_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] bin_in,
  input  logic             en,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] bin_out,
  output logic [N_REQ-1:0] pending,
  input  logic             ovf_clr,
  output logic [N_REQ-1:0] overflow,
  output logic [0:0]       state_dbg
);

  localparam logic [0:0]       S_IDLE  = IDLE;
  localparam logic [0:0]       S_OFFER = OFFER;
  localparam logic [N_REQ-1:0] ONE     = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [0:0]       state;
  logic [N_REQ-1:0] prev;
  logic [N_REQ-1:0] rise;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] ovf_set;
  logic [IDX_W-1:0] pick_idx;
  logic             any_set;
  logic             hs;

  pri_pick_16 u_pick (
    .vec     (pending),
    .idx     (pick_idx),
    .any_set (any_set)
  );

  assign out_valid = (state == S_OFFER);
  assign hs        = out_valid & out_ready;
  assign state_dbg = state;

  // prev resets to all ones so lines already high at reset release never
  // look like a fresh edge.
  assign rise    = bin_in & ~prev;
  assign clr     = hs ? (ONE << bin_out) : '0;
  // A re-request on a line that is being acknowledged this cycle is a
  // legitimate new request, not a loss.
  assign ovf_set = rise & pending & ~clr;

  // Edge capture, pending set/clear (set wins) and sticky overflow flags
  // (a new overflow wins over ovf_clr).
  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '1;
      pending  <= '0;
      overflow <= '0;
    end else begin
      prev     <= bin_in;
      pending  <= (pending & ~clr) | rise;
      overflow <= (ovf_clr ? '0 : overflow) | ovf_set;
    end
  end

  // Offer FSM: latch the highest pending index on entry to OFFER and hold it
  // until the handshake; bin_out keeps its last value while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      bin_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (en && any_set) begin
            state   <= S_OFFER;
            bin_out <= pick_idx;
          end
        end
        S_OFFER: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_capture_seq.sv
// Directed bench for req_capture_seq. Expected offer indices are queued
// when the stimulus that causes them is applied and popped when the DUT
// presents the offer.
module tb_req_capture_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bin_in;
  logic        en;
  logic        out_ready;
  logic        out_valid;
  logic [3:0]  bin_out;
  logic [15:0] pending;
  logic        ovf_clr;
  logic [15:0] overflow;
  logic [0:0]  state_dbg;

  logic [3:0]  exp_q[$];
  logic [3:0]  exp_v;
  int          n_cmp = 0;
  int          n_err = 0;

  // clock / reset
  always #5 clk = ~clk;

  req_capture_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bin_in    (bin_in),
    .en        (en),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .bin_out   (bin_out),
    .pending   (pending),
    .ovf_clr   (ovf_clr),
    .overflow  (overflow),
    .state_dbg (state_dbg)
  );

  // driver: advance one clock and settle just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard: compare the offered index with the next expected one
  task automatic check_offer(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s_queue: observed offer %0d expected no offer", tag, bin_out);
    end else begin
      exp_v = exp_q.pop_front();
      check({tag, "_idx"}, 32'(bin_out), 32'(exp_v));
    end
  endtask

  initial begin
    rst       = 1'b1;
    bin_in    = 16'h0001;
    en        = 1'b1;
    out_ready = 1'b1;
    ovf_clr   = 1'b0;
    repeat (3) tick();

    // reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_bin_out", 32'(bin_out), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_state", 32'(state_dbg), 32'd0);

    // line held high through reset release is not captured
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_pending", 32'(pending), 32'd0);
      check("held_valid", 32'(out_valid), 32'd0);
    end
    bin_in = 16'h0000;
    tick();

    // single edge on bit 3; level stays high afterwards
    bin_in = 16'h0008;
    exp_q.push_back(4'd3);
    tick();
    check("b3_pending", 32'(pending), 32'h0008);
    check("b3_valid_early", 32'(out_valid), 32'd0);
    tick();
    check_offer("b3_offer");
    tick();
    check("b3_valid_after", 32'(out_valid), 32'd0);
    check("b3_pending_after", 32'(pending), 32'd0);
    check("b3_idle_hold", 32'(bin_out), 32'd3);
    repeat (3) tick();
    check("b3_level_no_rereq", 32'(pending), 32'd0);
    check("b3_level_no_offer", 32'(out_valid), 32'd0);
    bin_in = 16'h0000;
    tick();

    // three simultaneous edges, served 15, 9, 2 two cycles apart
    bin_in = 16'h8204;
    exp_q.push_back(4'd15);
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd2);
    tick();
    check("multi_pending", 32'(pending), 32'h8204);
    tick();
    for (int k = 0; k < 3; k++) begin
      check_offer("multi_offer");
      tick();
      check("multi_gap", 32'(out_valid), 32'd0);
      tick();
    end
    check("multi_pending_end", 32'(pending), 32'd0);
    bin_in = 16'h0000;
    tick();

    // offer held stable while a higher-priority edge arrives
    out_ready = 1'b0;
    bin_in    = 16'h0020;
    exp_q.push_back(4'd5);
    tick();
    tick();
    check("hold_first", 32'(bin_out), 32'd5);
    check("hold_first_valid", 32'(out_valid), 32'd1);
    bin_in = 16'h1020;
    exp_q.push_back(4'd12);
    tick();
    check("hold_bin_out", 32'(bin_out), 32'd5);
    tick();
    check("hold_pending", 32'(pending), 32'h1020);
    check("hold_bin_out2", 32'(bin_out), 32'd5);
    out_ready = 1'b1;
    check_offer("hold_offer5");
    tick();
    check("hold_idle_valid", 32'(out_valid), 32'd0);
    check("hold_idle_pending", 32'(pending), 32'h1000);
    tick();
    check_offer("hold_offer12");
    tick();
    check("hold_pending_end", 32'(pending), 32'd0);
    bin_in = 16'h0000;
    tick();

    // overflow, ovf_clr, overflow vs ovf_clr, set-wins-over-clear
    en        = 1'b0;
    out_ready = 1'b0;
    bin_in    = 16'h0080;
    tick();
    check("ovf_pending", 32'(pending), 32'h0080);
    check("ovf_no_offer", 32'(out_valid), 32'd0);
    bin_in = 16'h0000;
    tick();
    bin_in = 16'h0080;
    tick();
    check("ovf_set", 32'(overflow), 32'h0080);
    check("ovf_pending_kept", 32'(pending), 32'h0080);
    bin_in  = 16'h0000;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);
    bin_in  = 16'h0080;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_beats_clr", 32'(overflow), 32'h0080);
    bin_in  = 16'h0000;
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared2", 32'(overflow), 32'd0);
    en = 1'b1;
    exp_q.push_back(4'd7);
    tick();
    check_offer("ack7_offer");
    out_ready = 1'b1;
    bin_in    = 16'h0080;
    tick();
    check("ack7_set_wins", 32'(pending), 32'h0080);
    check("ack7_no_ovf", 32'(overflow), 32'd0);
    check("ack7_idle", 32'(out_valid), 32'd0);
    exp_q.push_back(4'd7);
    tick();
    check_offer("ack7_reoffer");
    bin_in = 16'h0000;
    tick();
    check("ack7_pending_end", 32'(pending), 32'd0);

    // en gating, then reset during an offer
    en        = 1'b0;
    out_ready = 1'b0;
    bin_in    = 16'h0100;
    tick();
    bin_in = 16'h0000;
    tick();
    check("en_pending", 32'(pending), 32'h0100);
    check("en_no_offer", 32'(out_valid), 32'd0);
    tick();
    check("en_no_offer2", 32'(out_valid), 32'd0);
    en = 1'b1;
    exp_q.push_back(4'd8);
    tick();
    check_offer("en_offer8");
    tick();
    check("en_offer_held", 32'(out_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_pending", 32'(pending), 32'd0);
    check("rst_mid_bin_out", 32'(bin_out), 32'd0);
    rst = 1'b0;
    tick();
    check("rst_mid_stays_idle", 32'(out_valid), 32'd0);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
